arb_rr_pipe: RTL and testbench

Registered round-robin arbiter stage that selects one of `WIDTH` valid/ready request channels per cycle and presents the winner's data, index and one-hot grant on a single registered output channel. Sits directly upstream of the priority multiplexer path: its one-hot grant is the select vector for downstream priority/one-hot muxing. The output register decouples the arbitration and mux logic from downstream timing.

---
 rtl/arb_pkg.sv | 16 +
 rtl/arb_rr_pipe_if.sv | 31 +++
 rtl/oht_pry_base.sv | 12 +
 rtl/arb_rr_pipe.sv | 113 +++++++++++
 tb/tb_arb_rr_pipe.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter and one-hot mux blocks: implementation
// selector constants and the index-width helper.
package arb_pkg;

  typedef enum int {
    ARB_IMPL_MASK_PRIO = 0
  } arb_impl_e;

  // Index width for a WIDTH-way select, never narrower than one bit.
  function automatic int idx_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_rr_pipe_if.sv
// Request/output channel bundle for arb_rr_pipe. The slave modport is the
// arbiter; the master modport is the surrounding requesters and consumer.
interface arb_rr_pipe_if
  import arb_pkg::*;
#(
  parameter type DAT_T = logic [7:0],
  parameter int  WIDTH = 32
) ();

  localparam int IW = idx_w(WIDTH);

  logic [WIDTH-1:0] req_vld;
  DAT_T             req_dat [WIDTH];
  logic [WIDTH-1:0] req_rdy;
  logic             out_vld;
  DAT_T             out_dat;
  logic [IW-1:0]    out_idx;
  logic [WIDTH-1:0] out_oht;
  logic             out_rdy;

  modport slave (
    input  req_vld, req_dat, out_rdy,
    output req_rdy, out_vld, out_dat, out_idx, out_oht
  );

  modport master (
    output req_vld, req_dat, out_rdy,
    input  req_rdy, out_vld, out_dat, out_idx, out_oht
  );

endinterface

// File: rtl/oht_pry_base.sv
// Lowest-index-first priority encoder: keeps only the lowest set bit of vec.
module oht_pry_base #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] oht
);

  // Two's-complement isolate-lowest-set-bit trick.
  assign oht = vec & (~vec + WIDTH'(1));

endmodule

// File: rtl/arb_rr_pipe.sv
// Registered round-robin arbiter stage with one-hot grant output.
// Define ARB_RR_PIPE_FIXED_EN for a fixed-priority build (lowest index wins, no pointer).
module arb_rr_pipe
  import arb_pkg::*;
#(
  parameter type DAT_T          = logic [7:0],
  parameter int  WIDTH          = 32,
  parameter int  IMPLEMENTATION = 0
) (
  input logic          clk,
  input logic          rst,
  arb_rr_pipe_if.slave bus
);

  localparam int IW = idx_w(WIDTH);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "arb_rr_pipe: WIDTH must be at least 2");
    end
    if (IMPLEMENTATION != int'(ARB_IMPL_MASK_PRIO)) begin : g_bad_impl
      $fatal(1, "arb_rr_pipe: unsupported IMPLEMENTATION");
    end
  endgenerate

  logic [WIDTH-1:0] req_vld;
  logic [WIDTH-1:0] unmasked_oht;
  logic [WIDTH-1:0] grant;
  logic [IW-1:0]    grant_idx;
  DAT_T             grant_dat;
  logic             ld;
  logic             xfer;

  logic             out_vld_reg;
  DAT_T             out_dat_reg;
  logic [IW-1:0]    out_idx_reg;
  logic [WIDTH-1:0] out_oht_reg;

  assign req_vld = bus.req_vld;

  oht_pry_base #(.WIDTH(WIDTH)) u_pry_unmasked (
    .vec (req_vld),
    .oht (unmasked_oht)
  );

`ifdef ARB_RR_PIPE_FIXED_EN
  assign grant = unmasked_oht;
`else
  logic [IW-1:0]    ptr_reg;
  logic [WIDTH-1:0] masked_vld;
  logic [WIDTH-1:0] masked_oht;

  // Only channels strictly above the last winner compete in the masked search.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign masked_vld[gi] = req_vld[gi] & (IW'(gi) > ptr_reg);
  end

  oht_pry_base #(.WIDTH(WIDTH)) u_pry_masked (
    .vec (masked_vld),
    .oht (masked_oht)
  );

  assign grant = (|masked_vld) ? masked_oht : unmasked_oht;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= IW'(WIDTH - 1);
    end else if (xfer) begin
      ptr_reg <= grant_idx;
    end
  end
`endif

  // Grant is one-hot, so at most one branch fires.
  always_comb begin
    grant_idx = '0;
    grant_dat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant[i]) begin
        grant_idx = IW'(i);
        grant_dat = bus.req_dat[i];
      end
    end
  end

  assign ld   = ~out_vld_reg | bus.out_rdy;
  assign xfer = ld & (|req_vld);

  // rst gates ready so nothing is accepted while the stage is being cleared.
  assign bus.req_rdy = grant & {WIDTH{ld & ~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_reg <= 1'b0;
      out_dat_reg <= '0;
      out_idx_reg <= '0;
      out_oht_reg <= '0;
    end else if (ld) begin
      out_vld_reg <= |req_vld;
      if (|req_vld) begin
        out_dat_reg <= grant_dat;
        out_idx_reg <= grant_idx;
        out_oht_reg <= grant;
      end
    end
  end

  assign bus.out_vld = out_vld_reg;
  assign bus.out_dat = out_dat_reg;
  assign bus.out_idx = out_idx_reg;
  assign bus.out_oht = out_oht_reg;

endmodule

// File: tb/tb_arb_rr_pipe.sv
// Directed table-driven bench for arb_rr_pipe at WIDTH=4, with hand-written
// asynchronous-reset sequences; follows ARB_RR_PIPE_FIXED_EN when defined.
module tb_arb_rr_pipe;

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [1:0] e_idx;
    logic [3:0] e_oht;
    logic [7:0] e_dat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];

  arb_rr_pipe_if #(.DAT_T(logic [7:0]), .WIDTH(4)) bus ();

  arb_rr_pipe #(
    .DAT_T          (logic [7:0]),
    .WIDTH          (4),
    .IMPLEMENTATION (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] vld, input logic rdy, input logic [3:0] e_rdy,
                     input logic e_vld, input logic [1:0] e_idx, input logic [3:0] e_oht,
                     input logic [7:0] e_dat);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_idx = e_idx; v.e_oht = e_oht; v.e_dat = e_dat;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string tag, input logic e_vld, input logic [1:0] e_idx,
                         input logic [3:0] e_oht, input logic [7:0] e_dat);
    chk({tag, ".out_vld"}, 32'(bus.out_vld), 32'(e_vld));
    chk({tag, ".out_idx"}, 32'(bus.out_idx), 32'(e_idx));
    chk({tag, ".out_oht"}, 32'(bus.out_oht), 32'(e_oht));
    chk({tag, ".out_dat"}, 32'(bus.out_dat), 32'(e_dat));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4; i++) bus.req_dat[i] = 8'hA0 + 8'(i);
    bus.req_vld = 4'b0000;
    bus.out_rdy = 1'b0;
    rst = 1'b1;

`ifdef ARB_RR_PIPE_FIXED_EN
    // Fixed priority: channel 1 always beats 2; lowest index always wins.
    add(4'b0110, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0110, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0110, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0110, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0110, 0, 4'b0000, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b1111, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
    add(4'b1111, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
    add(4'b1000, 1, 4'b1000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b0000, 1, 4'b0000, 0, 2'd3, 4'b1000, 8'hA3);
`else
    // Fairness: full request set rotates 0,1,2,3,0.
    add(4'b1111, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
    add(4'b1111, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b1111, 1, 4'b0100, 1, 2'd2, 4'b0100, 8'hA2);
    add(4'b1111, 1, 4'b1000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b1111, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
    // Skip: grant 1, then 1010 alternates 3,1,3.
    add(4'b1111, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b1010, 1, 4'b1000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b1010, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b1010, 1, 4'b1000, 1, 2'd3, 4'b1000, 8'hA3);
    // Backpressure: three stalled cycles, then load on out_rdy rise.
    add(4'b1111, 0, 4'b0000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b1111, 0, 4'b0000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b1111, 0, 4'b0000, 1, 2'd3, 4'b1000, 8'hA3);
    add(4'b1111, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
    // Idle/drain: out_vld falls, payload holds, pointer stays at 0.
    add(4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0001, 8'hA0);
    add(4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0001, 8'hA0);
    add(4'b1111, 1, 4'b0010, 1, 2'd1, 4'b0010, 8'hA1);
    // Stall with requests dropped, then single requesters.
    add(4'b1111, 0, 4'b0000, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0000, 0, 4'b0000, 1, 2'd1, 4'b0010, 8'hA1);
    add(4'b0100, 1, 4'b0100, 1, 2'd2, 4'b0100, 8'hA2);
    add(4'b0001, 1, 4'b0001, 1, 2'd0, 4'b0001, 8'hA0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 2'd0, 4'b0000, 8'h00);
    rst = 1'b0;

    foreach (tbl[k]) begin
      bus.req_vld = tbl[k].vld;
      bus.out_rdy = tbl[k].rdy;
      #1;
      chk($sformatf("v%0d.req_rdy", k), 32'(bus.req_rdy), 32'(tbl[k].e_rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", k), tbl[k].e_vld, tbl[k].e_idx, tbl[k].e_oht, tbl[k].e_dat);
      $display("vec %0d: req_vld=%b out_rdy=%b -> req_rdy=%b out_vld=%b idx=%0d oht=%b dat=%h",
               k, tbl[k].vld, tbl[k].rdy, bus.req_rdy, bus.out_vld, bus.out_idx,
               bus.out_oht, bus.out_dat);
    end

    // Asynchronous reset mid-cycle while holding a valid word.
    bus.req_vld = 4'b1111;
    bus.out_rdy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 4'b0000, 8'h00);
    chk("async_rst.req_rdy", 32'(bus.req_rdy), 32'h0);
    $display("async reset mid-cycle: out_vld=%b req_rdy=%b", bus.out_vld, bus.req_rdy);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.req_rdy", 32'(bus.req_rdy), 32'h1);
    @(posedge clk);
    #1;
    chk_out("post_rst", 1'b1, 2'd0, 4'b0001, 8'hA0);
    $display("first grant after reset: idx=%0d dat=%h", bus.out_idx, bus.out_dat);

    bus.req_vld = 4'b0000;
    @(posedge clk);
    #1;
    chk("final_drain.out_vld", 32'(bus.out_vld), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
